// File: rtl/acc_req_arbiter.sv
// Round-robin arbiter sharing Ara's accelerator request port between NumReq dispatchers.
// An in-order ID FIFO remembers each accepted source so responses are routed back to it.
module acc_req_arbiter #(
  parameter  int unsigned NumReq         = 2,
  parameter  int unsigned XLEN           = 64,
  parameter  int unsigned MaxOutstanding = 8,
  localparam int unsigned IdxW           = $clog2(NumReq),
  localparam int unsigned CntW           = $clog2(MaxOutstanding) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_valid_i,
  input  logic [NumReq*32-1:0]   req_insn_i,
  input  logic [NumReq*XLEN-1:0] req_rs1_i,
  input  logic [NumReq*XLEN-1:0] req_rs2_i,
  output logic [NumReq-1:0]      req_ready_o,
  output logic [NumReq-1:0]      resp_valid_o,
  output logic [XLEN-1:0]        resp_result_o,
  input  logic [NumReq-1:0]      resp_ready_i,
  output logic                   acc_req_valid_o,
  output logic [31:0]            acc_insn_o,
  output logic [XLEN-1:0]        acc_rs1_o,
  output logic [XLEN-1:0]        acc_rs2_o,
  input  logic                   acc_req_ready_i,
  input  logic                   acc_resp_valid_i,
  input  logic [XLEN-1:0]        acc_resp_result_i,
  output logic                   acc_resp_ready_o,
  output logic [CntW-1:0]        outstanding_o,
  output logic                   err_orphan_resp_o
);

  localparam int unsigned PtrW = CntW - 1;

  logic [IdxW-1:0] rr_q;
  logic [IdxW-1:0] lock_idx_q;
  logic            lock_q;
  logic [IdxW-1:0] win;
  logic            found;
  logic            grant;

  logic [IdxW-1:0] id_mem_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] head;
  logic            head_ready;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            orphan;
  logic            err_q;

  // Fullness comes from registered state only, so a same-cycle pop never enables a push.
  assign full  = (cnt_q == CntW'(MaxOutstanding));
  assign empty = (cnt_q == '0);
  assign head  = id_mem_q[rd_ptr_q];

  always_comb begin
    found = 1'b0;
    win   = lock_idx_q;
    if (lock_q) begin
      found = 1'b1;
    end else begin
      for (int unsigned i = 1; i <= NumReq; i++) begin
        for (int unsigned r = 0; r < NumReq; r++) begin
          if (!found && req_valid_i[r] && (((32'(rr_q) + i) % NumReq) == r)) begin
            found = 1'b1;
            win   = IdxW'(r);
          end
        end
      end
    end
    grant = found & ~full & rst_ni;
  end

  always_comb begin
    acc_insn_o  = '0;
    acc_rs1_o   = '0;
    acc_rs2_o   = '0;
    req_ready_o = '0;
    for (int unsigned r = 0; r < NumReq; r++) begin
      if (grant && (win == IdxW'(r))) begin
        acc_insn_o     = req_insn_i[r*32 +: 32];
        acc_rs1_o      = req_rs1_i[r*XLEN +: XLEN];
        acc_rs2_o      = req_rs2_i[r*XLEN +: XLEN];
        req_ready_o[r] = acc_req_ready_i;
      end
    end
  end

  assign acc_req_valid_o = grant;
  assign push            = grant & acc_req_ready_i;

  always_comb begin
    resp_valid_o = '0;
    head_ready   = 1'b0;
    for (int unsigned r = 0; r < NumReq; r++) begin
      if (head == IdxW'(r)) begin
        resp_valid_o[r] = rst_ni & acc_resp_valid_i & ~empty;
        head_ready      = resp_ready_i[r];
      end
    end
  end

  // An empty FIFO swallows any response so Ara never stalls on an orphan.
  assign acc_resp_ready_o  = rst_ni & (empty | head_ready);
  assign resp_result_o     = rst_ni ? acc_resp_result_i : '0;
  assign pop               = acc_resp_valid_i & ~empty & head_ready;
  assign orphan            = acc_resp_valid_i & empty;
  assign outstanding_o     = cnt_q;
  assign err_orphan_resp_o = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= IdxW'(NumReq - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        rr_q     <= win;
        lock_q   <= 1'b0;
      end else if (grant) begin
        lock_q     <= 1'b1;
        lock_idx_q <= win;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CntW'(1);
      if (orphan) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) id_mem_q[wr_ptr_q] <= win;
  end

  a_lock_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> req_valid_i[lock_idx_q]);

endmodule

// File: tb/tb_acc_req_arbiter.sv
// Randomized bench for acc_req_arbiter: sources and an Ara stub drive traffic, a
// rule-level model predicts grants, and a scoreboard matches routed responses.
module tb_acc_req_arbiter;
  localparam int NumReq = 2;
  localparam int XLEN   = 64;
  localparam int MaxOut = 8;
  localparam int CntW   = 4;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic [NumReq-1:0]      req_valid_i;
  logic [NumReq*32-1:0]   req_insn_i;
  logic [NumReq*XLEN-1:0] req_rs1_i;
  logic [NumReq*XLEN-1:0] req_rs2_i;
  logic [NumReq-1:0]      req_ready_o;
  logic [NumReq-1:0]      resp_valid_o;
  logic [XLEN-1:0]        resp_result_o;
  logic [NumReq-1:0]      resp_ready_i;
  logic                   acc_req_valid_o;
  logic [31:0]            acc_insn_o;
  logic [XLEN-1:0]        acc_rs1_o;
  logic [XLEN-1:0]        acc_rs2_o;
  logic                   acc_req_ready_i;
  logic                   acc_resp_valid_i;
  logic [XLEN-1:0]        acc_resp_result_i;
  logic                   acc_resp_ready_o;
  logic [CntW-1:0]        outstanding_o;
  logic                   err_orphan_resp_o;

  acc_req_arbiter #(.NumReq(NumReq), .XLEN(XLEN), .MaxOutstanding(MaxOut)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_insn_i(req_insn_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o), .resp_result_o(resp_result_o), .resp_ready_i(resp_ready_i),
    .acc_req_valid_o(acc_req_valid_o), .acc_insn_o(acc_insn_o),
    .acc_rs1_o(acc_rs1_o), .acc_rs2_o(acc_rs2_o), .acc_req_ready_i(acc_req_ready_i),
    .acc_resp_valid_i(acc_resp_valid_i), .acc_resp_result_i(acc_resp_result_i),
    .acc_resp_ready_o(acc_resp_ready_o), .outstanding_o(outstanding_o),
    .err_orphan_resp_o(err_orphan_resp_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    int              src;
    logic [XLEN-1:0] res;
  } exp_t;

  exp_t            exp_q[$];
  logic [XLEN-1:0] ara_q[$];
  int              checks = 0;
  int              failures = 0;
  int              req_pct = 100, rdy_pct = 100, resp_pct = 0, rr_pct = 100;
  bit              force_orphan = 1'b0;
  int              last_w, lock_w;
  bit              lock_m, err_exp;

  // Ara's "execution": any deterministic mix of the operands exposes mis-muxing.
  function automatic logic [XLEN-1:0] f_res(logic [31:0] insn, logic [XLEN-1:0] a,
                                            logic [XLEN-1:0] b);
    return (a + b) ^ {32'd0, insn} ^ (b << 7);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Stimulus: sources hold valid until accepted; Ara stub accepts and answers in order.
  initial begin : driver
    logic [NumReq-1:0] s_req;
    logic              s_acc, s_pop, held;
    logic [XLEN-1:0]   s_res;
    req_valid_i = '0; req_insn_i = '0; req_rs1_i = '0; req_rs2_i = '0;
    resp_ready_i = '0; acc_req_ready_i = 1'b0; acc_resp_valid_i = 1'b0;
    acc_resp_result_i = '0;
    forever begin
      @(negedge clk_i);
      s_req = req_ready_o;
      s_acc = acc_req_valid_o & acc_req_ready_i;
      s_res = f_res(acc_insn_o, acc_rs1_o, acc_rs2_o);
      s_pop = acc_resp_valid_i & acc_resp_ready_o;
      @(posedge clk_i);
      #1;
      held = 1'b0;
      if (!rst_ni) begin
        ara_q.delete();
      end else begin
        if (s_pop && ara_q.size() > 0) void'(ara_q.pop_front());
        if (s_acc) ara_q.push_back(s_res);
        held = acc_resp_valid_i & ~s_pop;
      end
      for (int r = 0; r < NumReq; r++) begin
        if (s_req[r]) req_valid_i[r] = 1'b0;
        if (!req_valid_i[r] && $urandom_range(99) < req_pct) begin
          req_valid_i[r]             = 1'b1;
          req_insn_i[r*32 +: 32]     = $urandom;
          req_rs1_i[r*XLEN +: XLEN]  = {$urandom, $urandom};
          req_rs2_i[r*XLEN +: XLEN]  = {$urandom, $urandom};
        end
        resp_ready_i[r] = ($urandom_range(99) < rr_pct);
      end
      acc_req_ready_i = ($urandom_range(99) < rdy_pct);
      if (!rst_ni) begin
        acc_resp_valid_i = 1'b0;
      end else if (!held) begin
        if (force_orphan && ara_q.size() == 0) begin
          acc_resp_valid_i  = 1'b1;
          acc_resp_result_i = {$urandom, $urandom};
        end else if (ara_q.size() > 0 && $urandom_range(99) < resp_pct) begin
          acc_resp_valid_i  = 1'b1;
          acc_resp_result_i = ara_q[0];
        end else begin
          acc_resp_valid_i = 1'b0;
        end
      end
    end
  end

  // Monitor + reference model: round-robin from the last winner, grant held while
  // stalled, no grant when MaxOut IDs are outstanding, responses return in issue order.
  initial begin : monitor
    int                sz, w, c;
    bit                ev;
    logic [NumReq-1:0] exp_rdy, oh;
    exp_t              h;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        exp_q.delete();
        last_w  = NumReq - 1;
        lock_m  = 1'b0;
        err_exp = 1'b0;
      end else begin
        sz = exp_q.size();
        check("outstanding", 64'(outstanding_o), 64'(sz));
        check("err_orphan", 64'(err_orphan_resp_o), 64'(err_exp));
        ev = 1'b0;
        w  = 0;
        if (sz < MaxOut) begin
          if (lock_m) begin
            ev = 1'b1;
            w  = lock_w;
          end else begin
            for (int k = 1; k <= NumReq; k++) begin
              c = (last_w + k) % NumReq;
              if (!ev && req_valid_i[c]) begin
                ev = 1'b1;
                w  = c;
              end
            end
          end
        end
        if (acc_resp_valid_i) begin
          if (sz == 0) begin
            check("orphan_ready", 64'(acc_resp_ready_o), 64'd1);
            check("orphan_resp_valid", 64'(resp_valid_o), 64'd0);
            err_exp = 1'b1;
          end else begin
            h  = exp_q[0];
            oh = '0;
            oh[h.src] = 1'b1;
            check("resp_valid", 64'(resp_valid_o), 64'(oh));
            check("resp_result", resp_result_o, h.res);
            check("acc_resp_ready", 64'(acc_resp_ready_o), 64'(resp_ready_i[h.src]));
            if (resp_ready_i[h.src]) void'(exp_q.pop_front());
          end
        end else begin
          check("resp_valid_idle", 64'(resp_valid_o), 64'd0);
        end
        check("acc_req_valid", 64'(acc_req_valid_o), 64'(ev));
        exp_rdy = '0;
        if (ev) begin
          check("acc_insn", 64'(acc_insn_o), 64'(req_insn_i[w*32 +: 32]));
          check("acc_rs1", acc_rs1_o, req_rs1_i[w*XLEN +: XLEN]);
          check("acc_rs2", acc_rs2_o, req_rs2_i[w*XLEN +: XLEN]);
          if (acc_req_ready_i) begin
            exp_rdy[w] = 1'b1;
            exp_q.push_back('{src: w, res: f_res(req_insn_i[w*32 +: 32],
                                                 req_rs1_i[w*XLEN +: XLEN],
                                                 req_rs2_i[w*XLEN +: XLEN])});
            last_w = w;
            lock_m = 1'b0;
          end else begin
            lock_m = 1'b1;
            lock_w = w;
          end
        end
        check("req_ready", 64'(req_ready_o), 64'(exp_rdy));
      end
    end
  end

  task automatic check_all_zero(string tag);
    check({tag, "_acc_req_valid"}, 64'(acc_req_valid_o), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready_o), 64'd0);
    check({tag, "_acc_insn"}, 64'(acc_insn_o), 64'd0);
    check({tag, "_resp_valid"}, 64'(resp_valid_o), 64'd0);
    check({tag, "_resp_result"}, resp_result_o, 64'd0);
    check({tag, "_acc_resp_ready"}, 64'(acc_resp_ready_o), 64'd0);
    check({tag, "_outstanding"}, 64'(outstanding_o), 64'd0);
    check({tag, "_err"}, 64'(err_orphan_resp_o), 64'd0);
  endtask

  task automatic drain(string tag);
    int n;
    req_pct = 0; rdy_pct = 100; resp_pct = 100; rr_pct = 100;
    n = 0;
    while ((exp_q.size() != 0 || req_valid_i != '0) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL %s actual=%0d required=0 (outstanding after budget)", tag, exp_q.size());
    end
  endtask

  initial begin : main
    int n;
    // Reset with both sources requesting: every output must stay low.
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");

    // Both sources always valid, Ara always ready, no responses: 0,1,0,1 then fill.
    @(posedge clk_i); #3 rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    check("alt_outstanding", 64'(outstanding_o), 64'd4);
    repeat (10) @(negedge clk_i);
    check("full_outstanding", 64'(outstanding_o), 64'(MaxOut));
    check("full_no_grant", 64'(acc_req_valid_o), 64'd0);

    // Release responses: first pop cannot push, later cycles push+pop together.
    resp_pct = 100;
    repeat (20) @(negedge clk_i);

    req_pct = 60; rdy_pct = 50; resp_pct = 40; rr_pct = 70;
    repeat (3000) @(negedge clk_i);
    drain("drain1");

    // Response with nothing outstanding: dropped, error sticky.
    force_orphan = 1'b1;
    repeat (3) @(negedge clk_i);
    force_orphan = 1'b0;
    repeat (5) @(negedge clk_i);
    check("err_sticky", 64'(err_orphan_resp_o), 64'd1);

    // Build up outstanding IDs, stall Ara to lock a grant, then reset mid-flight.
    req_pct = 100; rdy_pct = 100; resp_pct = 0;
    n = 0;
    while (exp_q.size() < 3 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    rdy_pct = 0;
    repeat (3) @(negedge clk_i);
    check("pre_reset_lock_valid", 64'(acc_req_valid_o), 64'd1);
    @(posedge clk_i); #3 rst_ni = 1'b0;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #3 rst_ni = 1'b1;

    req_pct = 70; rdy_pct = 60; resp_pct = 50; rr_pct = 60;
    repeat (800) @(negedge clk_i);
    drain("drain2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
